// File: rtl/rx_frame_checker_pkg.sv
// Shared types and constants for the Rx frame checker: FSM states,
// error codes and the default sync word.
package rx_frame_checker_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_SYNC1   = 3'd1,
        ST_SEQ     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4
    } state_e;

    localparam logic [2:0] ERR_OK      = 3'd0;
    localparam logic [2:0] ERR_SYNC    = 3'd1;
    localparam logic [2:0] ERR_LEN     = 3'd2;
    localparam logic [2:0] ERR_PAYLOAD = 3'd3;
    localparam logic [2:0] ERR_CHK     = 3'd4;
    localparam logic [2:0] ERR_ABORT   = 3'd5;

    localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hEB90;

endpackage

// File: rtl/rx_frame_chk_popcount8.sv
// Combinational population count of one byte.
module rx_frame_chk_popcount8 (
    input  logic [7:0] data_i,
    output logic [3:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < 8; i++) begin
            count_o = count_o + {3'b000, data_i[i]};
        end
    end

endmodule

// File: rtl/rx_frame_checker.sv
// Checks received test frames (sync, sequence, counting payload, XOR checksum)
// and keeps saturating good/bad/lost/bit-error statistics.
module rx_frame_checker
    import rx_frame_checker_pkg::*;
#(
    parameter int          PAYLOAD_LEN = 16,
    parameter logic [15:0] SYNC_WORD   = DEFAULT_SYNC_WORD,
    parameter int          CNT_W       = 16
) (
    input  logic             clk_32M768,
    input  logic             rst_n_32M768,
    input  logic [7:0]       data_tdata,
    input  logic             data_tvalid,
    input  logic             data_tuser,
    input  logic             data_tlast,
    input  logic             cnt_clear,
    output logic             frame_done,
    output logic             frame_ok,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt,
    output logic [CNT_W-1:0] lost_cnt,
    output logic [31:0]      bit_err_cnt,
    output logic             locked
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [7:0]       SYNC_HI  = SYNC_WORD[15:8];
    localparam logic [7:0]       SYNC_LO  = SYNC_WORD[7:0];
    localparam logic [7:0]       LAST_IDX = 8'(PAYLOAD_LEN - 1);

    state_e     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] chk_q, chk_d;
    logic [7:0] seq_q, seq_d;
    logic       pay_err_q, pay_err_d;
    logic       frame_done_q, done_d;
    logic       frame_ok_q, ok_d;
    logic [2:0] err_code_q, err_d;
    logic       bit_add_v;

    logic [CNT_W-1:0] good_q, bad_q, lost_q;
    logic [31:0]      bit_err_q;
    logic             locked_q;
    logic [7:0]       exp_seq_q;

    logic [3:0]       pop_cnt;
    logic [32:0]      bit_err_sum;
    logic [31:0]      bit_err_sat;
    logic [7:0]       seq_diff;
    logic [CNT_W+8:0] lost_sum;
    logic [CNT_W-1:0] lost_sat;

    rx_frame_chk_popcount8 u_popcount (
        .data_i  (data_tdata ^ idx_q),
        .count_o (pop_cnt)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        chk_d     = chk_q;
        seq_d     = seq_q;
        pay_err_d = pay_err_q;
        done_d    = 1'b0;
        ok_d      = 1'b0;
        err_d     = ERR_OK;
        bit_add_v = 1'b0;
        if (data_tvalid) begin
            if (data_tuser && state_q != ST_HUNT) begin
                // Report the abort; the same byte restarts frame acquisition.
                done_d  = 1'b1;
                err_d   = ERR_ABORT;
                state_d = (data_tdata == SYNC_HI) ? ST_SYNC1 : ST_HUNT;
            end else begin
                case (state_q)
                    ST_HUNT: begin
                        if (data_tuser) begin
                            if (data_tdata != SYNC_HI) begin
                                done_d = 1'b1;
                                err_d  = ERR_SYNC;
                            end else if (data_tlast) begin
                                done_d = 1'b1;
                                err_d  = ERR_LEN;
                            end else begin
                                state_d = ST_SYNC1;
                            end
                        end
                    end
                    ST_SYNC1: begin
                        if (data_tdata != SYNC_LO) begin
                            done_d  = 1'b1;
                            err_d   = ERR_SYNC;
                            state_d = ST_HUNT;
                        end else if (data_tlast) begin
                            done_d  = 1'b1;
                            err_d   = ERR_LEN;
                            state_d = ST_HUNT;
                        end else begin
                            state_d = ST_SEQ;
                        end
                    end
                    ST_SEQ: begin
                        seq_d     = data_tdata;
                        chk_d     = data_tdata;
                        pay_err_d = 1'b0;
                        idx_d     = '0;
                        if (data_tlast) begin
                            done_d  = 1'b1;
                            err_d   = ERR_LEN;
                            state_d = ST_HUNT;
                        end else begin
                            state_d = ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        bit_add_v = 1'b1;
                        chk_d     = chk_q ^ data_tdata;
                        idx_d     = idx_q + 8'd1;
                        if (data_tdata != idx_q) begin
                            pay_err_d = 1'b1;
                        end
                        if (data_tlast) begin
                            done_d  = 1'b1;
                            err_d   = ERR_LEN;
                            state_d = ST_HUNT;
                        end else if (idx_q == LAST_IDX) begin
                            state_d = ST_CHK;
                        end
                    end
                    ST_CHK: begin
                        done_d  = 1'b1;
                        state_d = ST_HUNT;
                        if (!data_tlast) begin
                            err_d = ERR_LEN;
                        end else if (data_tdata != chk_q) begin
                            err_d = ERR_CHK;
                        end else if (pay_err_q) begin
                            err_d = ERR_PAYLOAD;
                        end else begin
                            ok_d = 1'b1;
                        end
                    end
                    default: state_d = ST_HUNT;
                endcase
            end
        end
    end

    always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
        if (!rst_n_32M768) begin
            state_q      <= ST_HUNT;
            idx_q        <= '0;
            chk_q        <= '0;
            seq_q        <= '0;
            pay_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            err_code_q   <= ERR_OK;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            chk_q        <= chk_d;
            seq_q        <= seq_d;
            pay_err_q    <= pay_err_d;
            frame_done_q <= done_d;
            frame_ok_q   <= ok_d;
            err_code_q   <= err_d;
        end
    end

    assign bit_err_sum = {1'b0, bit_err_q} + 33'(pop_cnt);
    assign bit_err_sat = bit_err_sum[32] ? 32'hFFFF_FFFF : bit_err_sum[31:0];
    assign seq_diff    = seq_q - exp_seq_q;
    assign lost_sum    = (CNT_W+9)'(lost_q) + (CNT_W+9)'(seq_diff);
    assign lost_sat    = (lost_sum > (CNT_W+9)'(CNT_MAX)) ? CNT_MAX : lost_sum[CNT_W-1:0];

    // Frame statistics follow the registered verdict, so a clear issued
    // while frame_done is high overrides that frame's increment.
    always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
        if (!rst_n_32M768) begin
            good_q    <= '0;
            bad_q     <= '0;
            lost_q    <= '0;
            bit_err_q <= '0;
            locked_q  <= 1'b0;
            exp_seq_q <= '0;
        end else if (cnt_clear) begin
            good_q    <= '0;
            bad_q     <= '0;
            lost_q    <= '0;
            bit_err_q <= '0;
            locked_q  <= 1'b0;
        end else begin
            if (bit_add_v) begin
                bit_err_q <= bit_err_sat;
            end
            if (frame_done_q) begin
                if (frame_ok_q) begin
                    good_q    <= (good_q == CNT_MAX) ? good_q : good_q + 1'b1;
                    locked_q  <= 1'b1;
                    exp_seq_q <= seq_q + 8'd1;
                    if (locked_q && seq_q != exp_seq_q) begin
                        lost_q <= lost_sat;
                    end
                end else begin
                    bad_q <= (bad_q == CNT_MAX) ? bad_q : bad_q + 1'b1;
                end
            end
        end
    end

    assign frame_done  = frame_done_q;
    assign frame_ok    = frame_ok_q;
    assign err_code    = err_code_q;
    assign good_cnt    = good_q;
    assign bad_cnt     = bad_q;
    assign lost_cnt    = lost_q;
    assign bit_err_cnt = bit_err_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_rx_frame_checker.sv
// Directed bench for rx_frame_checker: clean, corrupted, aborted, truncated
// and lost-sequence frames, counter saturation, clear and reset behaviour.
module tb_rx_frame_checker;

    localparam int LEN = 16;
    localparam int CW  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    tdata;
    logic          tvalid, tuser, tlast, cnt_clear;
    logic          frame_done, frame_ok, locked;
    logic [2:0]    err_code;
    logic [CW-1:0] good_cnt, bad_cnt, lost_cnt;
    logic [31:0]   bit_err_cnt;

    int n_checks  = 0;
    int n_fail    = 0;
    int gap       = 0;
    int exp_done  = 0;
    int done_count = 0;
    logic [2:0] err_log [0:1023];
    logic       ok_log  [0:1023];

    always #5 clk = ~clk;

    rx_frame_checker #(
        .PAYLOAD_LEN (LEN),
        .SYNC_WORD   (16'hEB90),
        .CNT_W       (CW)
    ) dut (
        .clk_32M768   (clk),
        .rst_n_32M768 (rst_n),
        .data_tdata   (tdata),
        .data_tvalid  (tvalid),
        .data_tuser   (tuser),
        .data_tlast   (tlast),
        .cnt_clear    (cnt_clear),
        .frame_done   (frame_done),
        .frame_ok     (frame_ok),
        .err_code     (err_code),
        .good_cnt     (good_cnt),
        .bad_cnt      (bad_cnt),
        .lost_cnt     (lost_cnt),
        .bit_err_cnt  (bit_err_cnt),
        .locked       (locked)
    );

    // Log every frame verdict so directed steps can inspect them afterwards.
    always @(negedge clk) begin
        if (rst_n && frame_done) begin
            if (done_count < 1024) begin
                err_log[done_count] = err_code;
                ok_log[done_count]  = frame_ok;
            end
            done_count = done_count + 1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put(input logic [7:0] d, input logic u, input logic l);
        @(negedge clk);
        tdata  = d;
        tuser  = u;
        tlast  = l;
        tvalid = 1'b1;
        @(negedge clk);
        tvalid = 1'b0;
        tuser  = 1'b0;
        tlast  = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // chk_fix=1 computes CHK over the transmitted (possibly corrupted) bytes.
    task automatic send_frame(input logic [7:0] seq, input int bad_idx, input logic [7:0] bad_xor,
                              input bit chk_fix, input int stop_after, input int tlast_at);
        logic [7:0] chk;
        logic [7:0] b;
        put(8'hEB, 1'b1, 1'b0);
        put(8'h90, 1'b0, 1'b0);
        put(seq, 1'b0, 1'b0);
        chk = seq;
        for (int k = 0; k < LEN; k++) begin
            if (k == stop_after) return;
            b = 8'(k);
            if (k == bad_idx) b = b ^ bad_xor;
            chk = chk ^ (chk_fix ? b : 8'(k));
            put(b, 1'b0, k == tlast_at);
            if (k == tlast_at) return;
        end
        put(chk, 1'b0, 1'b1);
    endtask

    task automatic clear_cnt();
        @(negedge clk);
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
    endtask

    task automatic check_last(input string tag, input logic [2:0] e_err, input logic e_ok);
        check({tag, " done_count"}, 32'(done_count), 32'(exp_done));
        check({tag, " err_code"}, 32'(err_log[exp_done-1]), 32'(e_err));
        check({tag, " frame_ok"}, 32'(ok_log[exp_done-1]), 32'(e_ok));
    endtask

    task automatic check_cnts(input string tag, input int g, input int bd, input int ls,
                              input int be, input logic lk);
        check({tag, " good_cnt"}, 32'(good_cnt), 32'(g));
        check({tag, " bad_cnt"}, 32'(bad_cnt), 32'(bd));
        check({tag, " lost_cnt"}, 32'(lost_cnt), 32'(ls));
        check({tag, " bit_err_cnt"}, bit_err_cnt, 32'(be));
        check({tag, " locked"}, 32'(locked), 32'(lk));
    endtask

    initial begin
        rst_n = 1'b0; tdata = '0; tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0; cnt_clear = 1'b0;
        idle(3);
        check("reset frame_done", 32'(frame_done), 32'd0);
        check("reset frame_ok", 32'(frame_ok), 32'd0);
        check("reset err_code", 32'(err_code), 32'd0);
        check_cnts("reset", 0, 0, 0, 0, 1'b0);
        rst_n = 1'b1;
        idle(2);
        check("post-reset frame_done", 32'(frame_done), 32'd0);

        // Three clean frames, one byte every 16 cycles.
        gap = 14;
        for (int s = 0; s < 3; s++) begin
            send_frame(8'(s), -1, 8'h00, 1'b0, -1, -1);
            exp_done++;
        end
        gap = 0;
        idle(4);
        check_last("clean3", 3'd0, 1'b1);
        check_cnts("clean3", 3, 0, 0, 0, 1'b1);
        $display("step clean3: done=%0d good=%0d locked=%0d", done_count, good_cnt, locked);

        clear_cnt();
        check_cnts("clear", 0, 0, 0, 0, 1'b0);

        // Byte 5 corrupted by 0x81 with the uncorrupted CHK: checksum error.
        send_frame(8'd3, 5, 8'h81, 1'b0, -1, -1);
        exp_done++;
        idle(4);
        check_last("chkerr", 3'd4, 1'b0);
        check_cnts("chkerr", 0, 1, 0, 2, 1'b0);
        $display("step chkerr: err=%0d bad=%0d biterr=%0d", err_log[exp_done-1], bad_cnt, bit_err_cnt);

        // Corrupted byte with matching CHK: payload mismatch.
        send_frame(8'd4, 2, 8'h10, 1'b1, -1, -1);
        exp_done++;
        idle(4);
        check_last("payerr", 3'd3, 1'b0);
        check_cnts("payerr", 0, 2, 0, 3, 1'b0);
        $display("step payerr: err=%0d bad=%0d biterr=%0d", err_log[exp_done-1], bad_cnt, bit_err_cnt);

        // Sequence gaps: 7,10 -> 2 lost; 11 -> none; 5 after 11 -> 249; 20 after 5 -> saturate.
        clear_cnt();
        send_frame(8'd7, -1, 8'h00, 1'b0, -1, -1);
        send_frame(8'd10, -1, 8'h00, 1'b0, -1, -1);
        exp_done += 2;
        idle(4);
        check_last("seq7_10", 3'd0, 1'b1);
        check_cnts("seq7_10", 2, 0, 2, 0, 1'b1);
        send_frame(8'd11, -1, 8'h00, 1'b0, -1, -1);
        exp_done++;
        idle(4);
        check("seq11 lost_cnt", 32'(lost_cnt), 32'd2);
        send_frame(8'd5, -1, 8'h00, 1'b0, -1, -1);
        exp_done++;
        idle(4);
        check("seqwrap lost_cnt", 32'(lost_cnt), 32'd251);
        send_frame(8'd20, -1, 8'h00, 1'b0, -1, -1);
        exp_done++;
        idle(4);
        check_last("seqsat", 3'd0, 1'b1);
        check_cnts("seqsat", 5, 0, 255, 0, 1'b1);
        $display("step seq: lost=%0d good=%0d", lost_cnt, good_cnt);

        // tuser at payload byte 3 aborts; the same byte starts a clean frame.
        clear_cnt();
        send_frame(8'd0, -1, 8'h00, 1'b0, 3, -1);
        send_frame(8'd1, -1, 8'h00, 1'b0, -1, -1);
        exp_done += 2;
        idle(4);
        check("abort err_code", 32'(err_log[exp_done-2]), 32'd5);
        check("abort frame_ok", 32'(ok_log[exp_done-2]), 32'd0);
        check_last("abort_next", 3'd0, 1'b1);
        check_cnts("abort", 1, 1, 0, 0, 1'b1);
        $display("step abort: errs=%0d,%0d good=%0d bad=%0d", err_log[exp_done-2], err_log[exp_done-1], good_cnt, bad_cnt);

        // Early tlast at payload byte 9, then a clean frame.
        clear_cnt();
        send_frame(8'd0, -1, 8'h00, 1'b0, -1, 9);
        exp_done++;
        idle(4);
        check_last("early_tlast", 3'd2, 1'b0);
        send_frame(8'd1, -1, 8'h00, 1'b0, -1, -1);
        exp_done++;
        idle(4);
        check_last("after_tlast", 3'd0, 1'b1);
        check_cnts("tlast", 1, 1, 0, 0, 1'b1);
        $display("step tlast: good=%0d bad=%0d", good_cnt, bad_cnt);

        // Second sync byte wrong.
        put(8'hEB, 1'b1, 1'b0);
        put(8'h91, 1'b0, 1'b0);
        exp_done++;
        idle(4);
        check_last("synclo", 3'd1, 1'b0);
        check("synclo bad_cnt", 32'(bad_cnt), 32'd2);

        // bad_cnt driven to all-ones, then one more bad frame.
        clear_cnt();
        for (int i = 0; i < 255; i++) begin
            put(8'h12, 1'b1, 1'b0);
            exp_done++;
        end
        idle(4);
        check("bad preset", 32'(bad_cnt), 32'd255);
        put(8'h12, 1'b1, 1'b0);
        exp_done++;
        idle(4);
        check_last("bad_sat", 3'd1, 1'b0);
        check("bad_sat bad_cnt", 32'(bad_cnt), 32'd255);
        $display("step badsat: bad=%0d done=%0d", bad_cnt, done_count);

        // Pulse timing, then clear coincident with frame_done.
        clear_cnt();
        send_frame(8'd0, -1, 8'h00, 1'b0, -1, -1);
        exp_done++;
        check("pulse frame_done", 32'(frame_done), 32'd1);
        check("pulse frame_ok", 32'(frame_ok), 32'd1);
        check("pulse err_code", 32'(err_code), 32'd0);
        @(negedge clk);
        check("pulse width", 32'(frame_done), 32'd0);
        idle(2);
        check_cnts("preclear", 1, 0, 0, 0, 1'b1);
        send_frame(8'd1, 0, 8'hFF, 1'b0, -1, -1);
        exp_done++;
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        check_cnts("clear_coinc", 0, 0, 0, 0, 1'b0);
        idle(3);
        check("clear_coinc done_count", 32'(done_count), 32'(exp_done));
        $display("step clear: good=%0d bad=%0d biterr=%0d locked=%0d", good_cnt, bad_cnt, bit_err_cnt, locked);

        // Reset in the middle of a frame: no verdict, next frame clean.
        send_frame(8'd5, -1, 8'h00, 1'b0, 4, -1);
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(20);
        check("midreset done_count", 32'(done_count), 32'(exp_done));
        send_frame(8'd6, -1, 8'h00, 1'b0, -1, -1);
        exp_done++;
        idle(4);
        check_last("midreset_next", 3'd0, 1'b1);
        check_cnts("midreset", 1, 0, 0, 0, 1'b1);
        $display("step midreset: done=%0d good=%0d", done_count, good_cnt);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
